// File: rtl/m_cache_pkg.sv
// Shared definitions for the direct-mapped read cache: FSM states and
// address-field geometry helpers.
package m_cache_pkg;

    localparam int BYTE_OFF_W = 2;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESP
    } state_t;

    function automatic int f_tag_w(input int addr_w, input int index_w, input int word_w);
        return addr_w - index_w - word_w - BYTE_OFF_W;
    endfunction

    function automatic int f_index_lsb(input int word_w);
        return word_w + BYTE_OFF_W;
    endfunction

    function automatic int f_tag_lsb(input int index_w, input int word_w);
        return index_w + word_w + BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/m_cache_line_ram.sv
// Tag and data storage for the cache: asynchronous read by line index,
// synchronous single-word / tag write. Contents are not reset.
module m_cache_line_ram
    import m_cache_pkg::*;
#(
    parameter int INDEX_W = 5,
    parameter int WORD_W  = 2,
    parameter int TAG_W   = 23
) (
    input  logic                i_clk,
    input  logic [INDEX_W-1:0]  i_rd_index,
    input  logic [WORD_W-1:0]   i_rd_word,
    output logic [TAG_W-1:0]    o_rd_tag,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_wr_data_en,
    input  logic [INDEX_W-1:0]  i_wr_index,
    input  logic [WORD_W-1:0]   i_wr_word,
    input  logic [DATA_W-1:0]   i_wr_data,
    input  logic                i_wr_tag_en,
    input  logic [TAG_W-1:0]    i_wr_tag
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << (INDEX_W + WORD_W);

    logic [DATA_W-1:0] r_data [WORDS];
    logic [TAG_W-1:0]  r_tag  [LINES];

    always_ff @(posedge i_clk) begin
        if (i_wr_data_en) begin
            r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
        end
        if (i_wr_tag_en) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
    end

    assign o_rd_tag  = r_tag[i_rd_index];
    assign o_rd_data = r_data[{i_rd_index, i_rd_word}];

endmodule

// File: rtl/m_dm_cache_ctrl.sv
// Direct-mapped read cache controller with line refill and one-cycle flush.
// Optional hit/miss counters are built when M_DM_CACHE_STATS_EN is defined.
module m_dm_cache_ctrl
    import m_cache_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 5,
    parameter int WORD_W  = 2
) (
    input  logic              w_clock,
    input  logic              w_reset_n,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    output logic              w_rsp_valid,
    output logic [31:0]       w_rsp_data,
    input  logic              w_flush,
    output logic              w_mem_req_valid,
    input  logic              w_mem_req_ready,
    output logic [ADDR_W-1:0] w_mem_req_addr,
    input  logic              w_mem_rsp_valid,
    input  logic [31:0]       w_mem_rsp_data
`ifdef M_DM_CACHE_STATS_EN
    ,
    output logic [31:0]       w_hit_count,
    output logic [31:0]       w_miss_count
`endif
);

    localparam int TAG_W     = f_tag_w(ADDR_W, INDEX_W, WORD_W);
    localparam int INDEX_LSB = f_index_lsb(WORD_W);
    localparam int TAG_LSB   = f_tag_lsb(INDEX_W, WORD_W);
    localparam int LINES     = 1 << INDEX_W;

    state_t             r_state;
    state_t             w_next_state;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag;
    logic [INDEX_W-1:0] r_index;
    logic [WORD_W-1:0]  r_word;
    logic [WORD_W-1:0]  r_cnt;
    logic               r_flush_pending;
    logic [31:0]        r_rsp_data;

    logic               w_do_flush;
    logic               w_req_fire;
    logic               w_hit;
    logic               w_mem_fire;
    logic               w_beat;
    logic               w_last_beat;
    logic [TAG_W-1:0]   w_ram_tag;
    logic [31:0]        w_ram_data;
    logic               w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^w_req_addr[1:0];

    assign w_do_flush  = (r_state == ST_IDLE) && (w_flush || r_flush_pending);
    assign w_req_fire  = w_req_valid && w_req_ready;
    assign w_hit       = r_valid[r_index] && (w_ram_tag == r_tag);
    assign w_mem_fire  = (r_state == ST_MISS_REQ) && w_mem_req_ready;
    assign w_beat      = (r_state == ST_REFILL) && w_mem_rsp_valid;
    assign w_last_beat = w_beat && (r_cnt == '1);

    m_cache_line_ram #(
        .INDEX_W (INDEX_W),
        .WORD_W  (WORD_W),
        .TAG_W   (TAG_W)
    ) u_line_ram (
        .i_clk        (w_clock),
        .i_rd_index   (r_index),
        .i_rd_word    (r_word),
        .o_rd_tag     (w_ram_tag),
        .o_rd_data    (w_ram_data),
        .i_wr_data_en (w_beat),
        .i_wr_index   (r_index),
        .i_wr_word    (r_cnt),
        .i_wr_data    (w_mem_rsp_data),
        .i_wr_tag_en  (w_last_beat),
        .i_wr_tag     (r_tag)
    );

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (w_req_fire)      w_next_state = ST_LOOKUP;
            ST_LOOKUP:   w_next_state = w_hit ? ST_IDLE : ST_MISS_REQ;
            ST_MISS_REQ: if (w_mem_req_ready) w_next_state = ST_REFILL;
            ST_REFILL:   if (w_last_beat)     w_next_state = ST_RESP;
            ST_RESP:     w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready     = 1'b0;
        w_rsp_valid     = 1'b0;
        w_rsp_data      = '0;
        w_mem_req_valid = 1'b0;
        w_mem_req_addr  = '0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = !(w_flush || r_flush_pending);
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_data  = w_ram_data;
                end
            end
            ST_MISS_REQ: begin
                w_mem_req_valid                        = 1'b1;
                w_mem_req_addr[ADDR_W-1:INDEX_LSB]     = {r_tag, r_index};
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                w_rsp_data  = r_rsp_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_tag      <= '0;
            r_index    <= '0;
            r_word     <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_req_fire) begin
                r_tag   <= w_req_addr[ADDR_W-1:TAG_LSB];
                r_index <= w_req_addr[TAG_LSB-1:INDEX_LSB];
                r_word  <= w_req_addr[INDEX_LSB-1:2];
            end
            if (w_mem_fire) begin
                r_cnt <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + WORD_W'(1);
            end
            if (w_beat && (r_cnt == r_word)) begin
                r_rsp_data <= w_mem_rsp_data;
            end
        end
    end

    // A line is invalidated at fetch handshake so a reset or flush mid-refill never exposes it.
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_valid         <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            if (w_do_flush) begin
                r_valid <= '0;
            end else if (w_mem_fire) begin
                r_valid[r_index] <= 1'b0;
            end else if (w_last_beat) begin
                r_valid[r_index] <= 1'b1;
            end
            if (w_do_flush) begin
                r_flush_pending <= 1'b0;
            end else if (w_flush && (r_state != ST_IDLE)) begin
                r_flush_pending <= 1'b1;
            end
        end
    end

`ifdef M_DM_CACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (w_hit && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (!w_hit && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign w_hit_count  = r_hit_count;
    assign w_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_m_dm_cache_ctrl.sv
// Directed self-checking bench for m_dm_cache_ctrl: miss/hit, conflict,
// backpressure, flush and reset-during-refill scenarios.
module tb_m_dm_cache_ctrl;

    logic        w_clock = 1'b0;
    logic        w_reset_n;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_data;
    logic        w_flush;
    logic        w_mem_req_valid;
    logic        w_mem_req_ready;
    logic [31:0] w_mem_req_addr;
    logic        w_mem_rsp_valid;
    logic [31:0] w_mem_rsp_data;
`ifdef M_DM_CACHE_STATS_EN
    logic [31:0] w_hit_count;
    logic [31:0] w_miss_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 w_clock = ~w_clock;

    m_dm_cache_ctrl #(
        .ADDR_W  (32),
        .INDEX_W (5),
        .WORD_W  (2)
    ) dut (
        .w_clock         (w_clock),
        .w_reset_n       (w_reset_n),
        .w_req_valid     (w_req_valid),
        .w_req_ready     (w_req_ready),
        .w_req_addr      (w_req_addr),
        .w_rsp_valid     (w_rsp_valid),
        .w_rsp_data      (w_rsp_data),
        .w_flush         (w_flush),
        .w_mem_req_valid (w_mem_req_valid),
        .w_mem_req_ready (w_mem_req_ready),
        .w_mem_req_addr  (w_mem_req_addr),
        .w_mem_rsp_valid (w_mem_rsp_valid),
        .w_mem_rsp_data  (w_mem_rsp_data)
`ifdef M_DM_CACHE_STATS_EN
        ,
        .w_hit_count     (w_hit_count),
        .w_miss_count    (w_miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Leaves the bench one cycle into LOOKUP for the accepted request.
    task automatic req(input logic [31:0] addr);
        @(negedge w_clock);
        w_req_valid = 1'b1;
        w_req_addr  = addr;
        #1 chk("req_ready", w_req_ready, 1);
        @(negedge w_clock);
        w_req_valid = 1'b0;
        w_req_addr  = 32'hDEAD_BEEC;
        #1;
    endtask

    task automatic hit(input logic [31:0] addr, input logic [31:0] exp);
        req(addr);
        chk("hit_rsp_valid", w_rsp_valid, 1);
        chk("hit_rsp_data", w_rsp_data, exp);
        chk("hit_no_memreq", w_mem_req_valid, 0);
        @(negedge w_clock);
        #1 chk("hit_then_idle", w_rsp_valid, 0);
    endtask

    task automatic miss_req(input logic [31:0] line, input int stall);
        chk("lookup_no_rsp", w_rsp_valid, 0);
        @(negedge w_clock);
        #1;
        for (int i = 0; i < stall; i++) begin
            chk("memreq_valid_hold", w_mem_req_valid, 1);
            chk("memreq_addr_hold", w_mem_req_addr, line);
            @(negedge w_clock);
            #1;
        end
        w_mem_req_ready = 1'b1;
        #1;
        chk("memreq_valid", w_mem_req_valid, 1);
        chk("memreq_addr", w_mem_req_addr, line);
        @(negedge w_clock);
        w_mem_req_ready = 1'b0;
        #1;
    endtask

    task automatic beats(input logic [31:0] base, input int gap, input int nbeats, input bit flush_mid);
        for (int i = 0; i < nbeats; i++) begin
            if (i > 0) repeat (gap) @(negedge w_clock);
            w_mem_rsp_valid = 1'b1;
            w_mem_rsp_data  = base + 32'(i);
            w_flush         = flush_mid && (i == 1);
            @(negedge w_clock);
            w_mem_rsp_valid = 1'b0;
            w_mem_rsp_data  = '0;
            w_flush         = 1'b0;
        end
        #1;
    endtask

    task automatic miss_fill(input logic [31:0] addr, input logic [31:0] line,
                             input logic [31:0] base, input int stall, input int gap,
                             input bit flush_mid, input logic [31:0] exp);
        req(addr);
        miss_req(line, stall);
        beats(base, gap, 4, flush_mid);
        chk("resp_valid", w_rsp_valid, 1);
        chk("resp_data", w_rsp_data, exp);
        chk("resp_not_ready", w_req_ready, 0);
        @(negedge w_clock);
        #1;
        chk("after_resp_valid", w_rsp_valid, 0);
        chk("after_resp_ready", w_req_ready, flush_mid ? 32'd0 : 32'd1);
        if (flush_mid) begin
            @(negedge w_clock);
            #1 chk("post_flush_ready", w_req_ready, 1);
        end
    endtask

    initial begin
        w_reset_n       = 1'b0;
        w_req_valid     = 1'b0;
        w_req_addr      = '0;
        w_flush         = 1'b0;
        w_mem_req_ready = 1'b0;
        w_mem_rsp_valid = 1'b0;
        w_mem_rsp_data  = '0;

        repeat (2) @(negedge w_clock);
        #1;
        chk("rst_req_ready", w_req_ready, 1);
        chk("rst_rsp_valid", w_rsp_valid, 0);
        chk("rst_rsp_data", w_rsp_data, 0);
        chk("rst_memreq_valid", w_mem_req_valid, 0);
        chk("rst_memreq_addr", w_mem_req_addr, 0);
        @(negedge w_clock);
        w_reset_n = 1'b1;
        #1;

        miss_fill(32'h0000_0124, 32'h0000_0120, 32'h0000_00A0, 0, 0, 1'b0, 32'h0000_00A1);
        hit(32'h0000_012C, 32'h0000_00A3);
`ifdef M_DM_CACHE_STATS_EN
        chk("stats_hit_1", w_hit_count, 1);
        chk("stats_miss_1", w_miss_count, 1);
`endif
        hit(32'h0000_0120, 32'h0000_00A0);

        miss_fill(32'h0000_2124, 32'h0000_2120, 32'h0000_00B0, 5, 2, 1'b0, 32'h0000_00B1);
        hit(32'h0000_2128, 32'h0000_00B2);
        miss_fill(32'h0000_0124, 32'h0000_0120, 32'h0000_00C0, 0, 0, 1'b0, 32'h0000_00C1);
        hit(32'h0000_0124, 32'h0000_00C1);

        miss_fill(32'h0000_0040, 32'h0000_0040, 32'h0000_0D00, 0, 1, 1'b1, 32'h0000_0D00);
        miss_fill(32'h0000_012C, 32'h0000_0120, 32'h0000_00E0, 0, 0, 1'b0, 32'h0000_00E3);

        @(negedge w_clock);
        w_flush     = 1'b1;
        w_req_valid = 1'b1;
        w_req_addr  = 32'h0000_012C;
        #1 chk("flush_req_ready", w_req_ready, 0);
        @(negedge w_clock);
        w_flush     = 1'b0;
        w_req_valid = 1'b0;
        #1;
        chk("flush_done_ready", w_req_ready, 1);
        chk("flush_no_lookup", w_rsp_valid, 0);
        miss_fill(32'h0000_0124, 32'h0000_0120, 32'h0000_0050, 0, 0, 1'b0, 32'h0000_0051);

        req(32'h0000_0350);
        miss_req(32'h0000_0350, 0);
        beats(32'h0000_0060, 0, 2, 1'b0);
        w_reset_n       = 1'b0;
        w_mem_rsp_valid = 1'b1;
        w_mem_rsp_data  = 32'h0000_0062;
        #1;
        chk("midrst_req_ready", w_req_ready, 1);
        chk("midrst_rsp_valid", w_rsp_valid, 0);
        chk("midrst_rsp_data", w_rsp_data, 0);
        chk("midrst_memreq_valid", w_mem_req_valid, 0);
        chk("midrst_memreq_addr", w_mem_req_addr, 0);
        @(negedge w_clock);
        w_reset_n      = 1'b1;
        w_mem_rsp_data = 32'h0000_0063;
        @(negedge w_clock);
        w_mem_rsp_valid = 1'b0;
        w_mem_rsp_data  = '0;
        #1;
        chk("postrst_req_ready", w_req_ready, 1);
        chk("postrst_rsp_valid", w_rsp_valid, 0);
`ifdef M_DM_CACHE_STATS_EN
        chk("stats_hit_rst", w_hit_count, 0);
        chk("stats_miss_rst", w_miss_count, 0);
`endif

        miss_fill(32'h0000_0350, 32'h0000_0350, 32'h0000_0070, 0, 0, 1'b0, 32'h0000_0070);
        hit(32'h0000_035C, 32'h0000_0073);
        miss_fill(32'h0000_0124, 32'h0000_0120, 32'h0000_0080, 0, 0, 1'b0, 32'h0000_0081);
`ifdef M_DM_CACHE_STATS_EN
        chk("stats_hit_end", w_hit_count, 1);
        chk("stats_miss_end", w_miss_count, 2);
`endif

        repeat (2) @(negedge w_clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_dm_cache_ctrl.md
Name: m_dm_cache_ctrl

Overview:
- Parametrised direct-mapped read cache with its own miss handling.
- Multi-word lines and a valid/ready request port toward the core.
- Line refill from backing memory over a request/beat handshake, plus whole-cache flush.
- Sits between the instruction/data fetch path and the memory bus.

Parameters:
- ADDR_W, 32, byte address width.
- INDEX_W, 5, log2 of line count (32 lines).
- WORD_W, 2, log2 of words per line (4 x 32-bit words).
- Data word is fixed at 32 bits.
- Byte offset is 2 bits.
- TAG_W = ADDR_W - INDEX_W - WORD_W - 2.

Ports:
- w_clock  in  1  single clock; all state updates on rising edge.
- w_reset_n  in  1  asynchronous, active-low reset.
- w_req_valid  in  1  core read request.
- w_req_ready  out  1  high only in IDLE with no flush pending.
- w_req_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- w_rsp_valid  out  1  one-cycle pulse with read data; core always accepts.
- w_rsp_data  out  32  read data, valid only while w_rsp_valid.
- w_flush  in  1  invalidate all lines.
- w_mem_req_valid  out  1  line fetch request.
- w_mem_req_ready  in  1  memory accepts fetch.
- w_mem_req_addr  out  ADDR_W  line-aligned address; low WORD_W+2 bits are zero.
- w_mem_rsp_valid  in  1  one refill beat.
- w_mem_rsp_data  in  32  beat data; beats arrive in word order 0..2^WORD_W-1.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE; all valid bits = 0; beat counter = 0; flush_pending = 0.
  - Outputs: w_req_ready=1 once state is IDLE; w_rsp_valid=0; w_rsp_data=0; w_mem_req_valid=0; w_mem_req_addr=0.
  - Data/tag arrays are not reset.
- Address split: tag=[ADDR_W-1:INDEX_W+WORD_W+2], index=[INDEX_W+WORD_W+1:WORD_W+2], word=[WORD_W+1:2].
- States: IDLE, LOOKUP, MISS_REQ, REFILL, RESP.
- IDLE:
  - If w_flush or flush_pending: clear all valid bits in one cycle, clear flush_pending, w_req_ready=0 that cycle.
  - Otherwise, on w_req_valid & w_req_ready: register the address and go to LOOKUP.
- LOOKUP:
  - hit = valid[index] & (tag_ram[index]==tag).
  - On hit: assert w_rsp_valid with data_ram[index][word] this cycle, then go to IDLE.
  - Hit latency is 1 cycle after acceptance; throughput is one request per 2 cycles.
  - On miss: go to MISS_REQ.
- MISS_REQ:
  - Hold w_mem_req_valid=1 with a stable w_mem_req_addr until w_mem_req_ready.
  - On handshake: beat counter = 0, clear valid[index], go to REFILL.
- REFILL:
  - Each w_mem_rsp_valid writes the beat into data_ram[index][counter].
  - If counter==word, also capture the beat into the response register.
  - Counter increments on each beat.
  - On the last beat: write tag_ram[index], set valid[index], go to RESP.
  - Cycles without w_mem_rsp_valid simply wait; there is no timeout.
- RESP: w_rsp_valid=1 for one cycle with the captured word, then go to IDLE.
- w_mem_rsp_valid outside REFILL is ignored.
- w_flush outside IDLE sets flush_pending. It never aborts a refill; the flush is applied in the next IDLE cycle, before any new request.
- Flush and request in the same IDLE cycle: flush wins and the request is not accepted (w_req_ready=0).
- Reset mid-refill: the line stays invalid (all valid bits clear). Memory beats arriving after reset are ignored.
- w_req_addr changes while not ready have no effect.

Optional Feature:
- Macro: M_DM_CACHE_STATS_EN.
- When defined, adds two outputs:
  - w_hit_count out 32: +1 per LOOKUP hit.
  - w_miss_count out 32: +1 per LOOKUP miss.
- Both counters saturate at 32'hFFFFFFFF, reset to 0, and are not cleared by flush.
- When undefined, these ports and counters are absent.

Decomposition:
- Shared package m_cache_pkg:
  - State encoding constants.
  - Address-field width/offset functions (TAG_W, index and word slice positions).
- One sub-module, m_cache_line_ram:
  - Tag + data arrays: asynchronous read by index, synchronous write of a data word or tag.
  - Parameterised by INDEX_W, WORD_W, TAG_W.
- Valid bits are kept in the controller as a flop vector so flush takes one cycle.

Test Plan:
- Cold miss, default params: read 0x0000_0124 → w_mem_req_addr=0x0000_0120; beats 0xA0,0xA1,0xA2,0xA3 → w_rsp_valid with w_rsp_data=0xA1 in the cycle after the last beat.
- Hit after fill: read 0x0000_012C → w_rsp_valid the cycle after acceptance, data=0xA3, w_mem_req_valid stays 0.
- Conflict: read 0x0000_2124 (same index 0x12, different tag) → miss and refill with 0xB0..0xB3, data=0xB1. A following read of 0x0000_0124 misses again.
- Backpressure: w_mem_req_ready low for 5 cycles → w_mem_req_valid and w_mem_req_addr stay stable. Gaps between beats → data is still correct.
- Flush: assert w_flush during REFILL → refill completes and the response is returned, then all lines are invalid. The next read of a previously hit address misses.
- Reset: assert w_reset_n=0 mid-REFILL, then release → outputs return to reset values and the partial line misses. With M_DM_CACHE_STATS_EN defined, after a miss then a hit: w_hit_count=1, w_miss_count=1.
